// File: rtl/fire_control_pkg.sv
// Shared constants for the trigger sequencer: attack mode, fire-select codes, state codes.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package fire_control_pkg;

    localparam logic [3:0] ATTACK_MODE = 4'b0010;

    localparam logic [1:0] SEL_SAFE   = 2'b00;
    localparam logic [1:0] SEL_SINGLE = 2'b01;
    localparam logic [1:0] SEL_BURST  = 2'b10;
    localparam logic [1:0] SEL_AUTO   = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRE   = 2'd1;
    localparam logic [1:0] ST_COOL   = 2'd2;
    localparam logic [1:0] ST_RELOAD = 2'd3;

    // Weapons may only discharge in attack mode with a non-safe selector.
    function automatic logic is_armed(input logic [3:0] mode, input logic [1:0] sel);
        return (mode == ATTACK_MODE) && (sel != SEL_SAFE);
    endfunction

endpackage

// File: rtl/fire_control_shot.sv
// shot_timer: 8-bit loadable down-counter timing the idle gap after a shot.
// Latency: load takes effect next cycle; expire is combinational from the count.
// Backpressure: none; it counts every cycle until it reaches zero.
//
// Ports: clk, rst (sync active-low), load / load_val (start a new gap),
//        expire (high on the last cycle of the gap, and whenever idle).
module shot_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    // The count holds the cycles left including the current one, so the
    // gap ends when one remains.
    assign expire = (cnt <= 8'd1);

endmodule

// File: rtl/fire_control.sv
// fire_control: turns trigger/select/reload requests into fire pulses and reload strobes.
// Latency: trigger edge or reload request at cycle t gives fire/load at t+1; all outputs registered.
// Backpressure: none accepted; shot spacing and magazine limits are enforced internally.
//
// Ports: clk, rst (sync active-low), mode, trigger, sel, cooldown, reload_req,
//        ammo (fed back from weapons stage), reserve (stores) ->
//        fire, load, load_val, drawn (valid while load), busy, dry.
module fire_control
    import fire_control_pkg::*;
#(
    parameter int             N          = 9,
    parameter logic [N-1:0]   MAG_SIZE   = 9'd300,
    parameter int             BURST_LEN  = 3,
    parameter int             RELOAD_CYC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   mode,
    input  logic         trigger,
    input  logic [1:0]   sel,
    input  logic [7:0]   cooldown,
    input  logic         reload_req,
    input  logic [N-1:0] ammo,
    input  logic [N-1:0] reserve,
    output logic         fire,
    output logic         load,
    output logic [N-1:0] load_val,
    output logic [N-1:0] drawn,
    output logic         busy,
    output logic         dry
);

    logic [1:0]   state;
    logic [1:0]   state_nx;
    logic         trig_q;
    logic         blk;       // blocks auto-fire on a trigger held since reset/reload
    logic [N-1:0] sh;        // shadow round count, ahead of the lagging ammo feedback
    logic [2:0]   bcnt;
    logic         auto_q;
    logic [7:0]   rcnt;

    logic         armed;
    logic         trig_edge;
    logic         attempt;
    logic         reload_go;
    logic [N:0]   sum;
    logic [N-1:0] lv_calc;
    logic [N-1:0] sh_dec;
    logic [2:0]   bcnt_dec;
    logic         more_fire;
    logic         more_cool;
    logic         tmr_load;
    logic         tmr_expire;

    assign armed     = is_armed(mode, sel);
    assign trig_edge = trigger & ~trig_q;
    // Auto fires on level, but a trigger held across reset or reload must be
    // released (or freshly pressed) first.
    assign attempt   = armed & ((sel == SEL_AUTO) ? (trigger & (~blk | ~trig_q)) : trig_edge);
    assign reload_go = reload_req & (reserve != '0) & (ammo < MAG_SIZE);

    // One extra bit so ammo + reserve cannot wrap before saturating.
    assign sum     = {1'b0, ammo} + {1'b0, reserve};
    assign lv_calc = (sum > {1'b0, MAG_SIZE}) ? MAG_SIZE : sum[N-1:0];

    assign sh_dec    = sh - N'(1);
    assign bcnt_dec  = bcnt - 3'd1;
    // In FIRE the counter is judged after this shot; in COOL it already is.
    assign more_fire = auto_q ? trigger : (bcnt_dec != 3'd0);
    assign more_cool = auto_q ? trigger : (bcnt != 3'd0);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (reload_go) begin
                    state_nx = ST_RELOAD;
                end else if (attempt && (sh != '0)) begin
                    state_nx = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (mode != ATTACK_MODE) begin
                    state_nx = ST_IDLE;
                end else if (cooldown != 8'd0) begin
                    state_nx = ST_COOL;
                end else if (more_fire && (sh_dec != '0)) begin
                    state_nx = ST_FIRE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_COOL: begin
                if (tmr_expire) begin
                    state_nx = (more_cool && (sh != '0) && armed) ? ST_FIRE : ST_IDLE;
                end
            end
            ST_RELOAD: begin
                if (rcnt <= 8'd1) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign tmr_load = (state == ST_FIRE) && (state_nx == ST_COOL);

    shot_timer u_shot_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (cooldown),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            trig_q   <= 1'b1;   // a trigger held through reset is not an edge
            blk      <= 1'b1;
            sh       <= '0;
            bcnt     <= 3'd0;
            auto_q   <= 1'b0;
            rcnt     <= 8'd0;
            fire     <= 1'b0;
            load     <= 1'b0;
            load_val <= '0;
            drawn    <= '0;
            busy     <= 1'b0;
            dry      <= 1'b0;
        end else begin
            state  <= state_nx;
            trig_q <= trigger;
            fire   <= (state_nx == ST_FIRE);
            load   <= (state_nx == ST_RELOAD);
            busy   <= (state_nx != ST_IDLE);
            dry    <= (state == ST_IDLE) && !reload_go && attempt && (sh == '0);

            case (state)
                ST_IDLE: begin
                    if (!trigger) begin
                        blk <= 1'b0;
                    end
                    if (reload_go) begin
                        load_val <= lv_calc;
                        drawn    <= lv_calc - ammo;
                        sh       <= lv_calc;
                        rcnt     <= 8'(RELOAD_CYC);
                        blk      <= 1'b1;
                    end else if (state_nx == ST_FIRE) begin
                        // Keep the shadow count: ammo may still lag a recent shot.
                        bcnt   <= (sel == SEL_BURST) ? 3'(BURST_LEN) : 3'd1;
                        auto_q <= (sel == SEL_AUTO);
                        blk    <= 1'b0;
                    end else begin
                        sh <= ammo;
                    end
                end
                ST_FIRE: begin
                    sh   <= sh_dec;
                    bcnt <= bcnt_dec;
                end
                ST_RELOAD: begin
                    rcnt <= rcnt - 8'd1;
                    if (state_nx == ST_IDLE) begin
                        load_val <= '0;
                        drawn    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fire_control.sv
// Bench for fire_control: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against a behavioural model.
// The bench also plays the weapons stage, feeding ammo back one cycle late.
module tb_fire_control;

    localparam int MAG   = 300;
    localparam int BURST = 3;
    localparam int RCYC  = 4;

    localparam int PH_READY = 0;
    localparam int PH_SHOT  = 1;
    localparam int PH_GAP   = 2;
    localparam int PH_LOAD  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] mode;
    logic       trigger;
    logic [1:0] sel;
    logic [7:0] cooldown;
    logic       reload_req;
    logic [8:0] ammo;
    logic [8:0] reserve;
    logic       fire;
    logic       load;
    logic [8:0] load_val;
    logic [8:0] drawn;
    logic       busy;
    logic       dry;

    fire_control dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .trigger    (trigger),
        .sel        (sel),
        .cooldown   (cooldown),
        .reload_req (reload_req),
        .ammo       (ammo),
        .reserve    (reserve),
        .fire       (fire),
        .load       (load),
        .load_val   (load_val),
        .drawn      (drawn),
        .busy       (busy),
        .dry        (dry)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int   ph = PH_READY;
    int   m_sh = 0, m_shots = 0, m_gap = 0, m_rl = 0, m_total = 0;
    bit   m_auto = 0, m_tprev = 1, m_blk = 1;
    bit   m_armed, m_edge, m_want, m_more, m_dry_n;
    logic e_fire = 0, e_load = 0, e_busy = 0, e_dry = 0;
    logic [8:0] e_lv = 0, e_dr = 0;

    always @(posedge clk) begin
        if (!rst) begin
            ph = PH_READY; m_sh = 0; m_shots = 0; m_gap = 0; m_rl = 0;
            m_auto = 0; m_tprev = 1; m_blk = 1;
            e_fire = 0; e_load = 0; e_busy = 0; e_dry = 0; e_lv = 0; e_dr = 0;
        end else begin
            m_armed = (mode == 4'b0010) && (sel != 2'b00);
            m_edge  = trigger && !m_tprev;
            m_dry_n = 0;
            case (ph)
                PH_READY: begin
                    if (!trigger) m_blk = 0;
                    if (reload_req && reserve != 0 && int'(ammo) < MAG) begin
                        m_total = int'(ammo) + int'(reserve);
                        e_lv = 9'((m_total > MAG) ? MAG : m_total);
                        e_dr = e_lv - ammo;
                        m_sh = int'(e_lv);
                        m_rl = RCYC;
                        m_blk = 1;
                        ph = PH_LOAD;
                    end else begin
                        m_want = m_armed && ((sel == 2'b11) ? (trigger && (!m_blk || m_edge)) : m_edge);
                        if (m_want && m_sh > 0) begin
                            m_shots = (sel == 2'b10) ? BURST : 1;
                            m_auto  = (sel == 2'b11);
                            m_blk   = 0;
                            ph = PH_SHOT;
                        end else begin
                            m_dry_n = m_want;
                            m_sh = int'(ammo);
                        end
                    end
                end
                PH_SHOT: begin
                    m_sh = m_sh - 1;
                    m_shots = m_shots - 1;
                    m_more = m_auto ? trigger : (m_shots > 0);
                    if (mode != 4'b0010) ph = PH_READY;
                    else if (cooldown > 0) begin ph = PH_GAP; m_gap = int'(cooldown); end
                    else if (m_more && m_sh > 0) ph = PH_SHOT;
                    else ph = PH_READY;
                end
                PH_GAP: begin
                    m_gap = m_gap - 1;
                    if (m_gap <= 0) begin
                        m_more = m_auto ? trigger : (m_shots > 0);
                        ph = (m_more && m_sh > 0 && m_armed) ? PH_SHOT : PH_READY;
                    end
                end
                default: begin
                    m_rl = m_rl - 1;
                    if (m_rl == 0) begin ph = PH_READY; e_lv = 0; e_dr = 0; end
                end
            endcase
            m_tprev = trigger;
            e_fire = (ph == PH_SHOT);
            e_load = (ph == PH_LOAD);
            e_busy = (ph != PH_READY);
            e_dry  = m_dry_n;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int d_fires = 0, m_fires = 0, d_drys = 0, m_drys = 0;
    bit prev_load = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Each cycle: compare at the falling edge, then act as the weapons stage
    // (ammo drops the cycle after a shot, reload lands on the first load cycle).
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            chk("fire", 32'(fire), 32'(e_fire));
            chk("load", 32'(load), 32'(e_load));
            chk("load_val", 32'(load_val), 32'(e_lv));
            chk("drawn", 32'(drawn), 32'(e_dr));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("dry", 32'(dry), 32'(e_dry));
            if (fire === 1'b1) d_fires++;
            if (dry === 1'b1) d_drys++;
            if (e_fire) m_fires++;
            if (e_dry) m_drys++;
            #1;
            if (e_fire && ammo != 0) ammo = ammo - 9'd1;
            if (e_load && !prev_load) begin
                ammo = e_lv;
                reserve = reserve - e_dr;
            end
            prev_load = e_load;
        end
    endtask

    int f0, mf0, dr0, mdr0;

    initial begin
        rst = 0; mode = 4'b0010; trigger = 0; sel = 2'b01; cooldown = 8'd2;
        reload_req = 0; ammo = 9'd5; reserve = 9'd0;
        tick(3);
        chk("reset_fire", 32'(fire), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_load_val", 32'(load_val), 32'd0);
        rst = 1;
        tick(3);

        // Single shot: trigger held 20 cycles gives one pulse, at edge+1.
        f0 = d_fires; mf0 = m_fires;
        trigger = 1;
        tick(1);
        chk("single_first", 32'(fire), 32'd1);
        tick(19);
        trigger = 0;
        tick(5);
        chk("single_count", 32'(d_fires - f0), 32'd1);
        chk("single_model", 32'(m_fires - mf0), 32'd1);

        // Burst with 2 rounds and no cooldown: two back-to-back shots, no dry.
        sel = 2'b10; cooldown = 8'd0; ammo = 9'd2;
        tick(2);
        f0 = d_fires; dr0 = d_drys;
        trigger = 1;
        tick(1);
        chk("burst_shot1", 32'(fire), 32'd1);
        tick(1);
        chk("burst_shot2", 32'(fire), 32'd1);
        tick(1);
        chk("burst_end_fire", 32'(fire), 32'd0);
        chk("burst_end_busy", 32'(busy), 32'd0);
        trigger = 0;
        tick(3);
        chk("burst_count", 32'(d_fires - f0), 32'd2);
        chk("burst_no_dry", 32'(d_drys - dr0), 32'd0);

        // Auto, cooldown 3, trigger held 16 cycles: four shots.
        sel = 2'b11; cooldown = 8'd3; ammo = 9'd100;
        tick(2);
        f0 = d_fires; mf0 = m_fires;
        trigger = 1;
        tick(16);
        trigger = 0;
        tick(6);
        chk("auto_count", 32'(d_fires - f0), 32'd4);
        chk("auto_model", 32'(m_fires - mf0), 32'd4);

        // Reload beats a simultaneous trigger edge.
        sel = 2'b01; cooldown = 8'd0; ammo = 9'd250; reserve = 9'd80;
        tick(2);
        f0 = d_fires;
        reload_req = 1; trigger = 1;
        tick(1);
        reload_req = 0;
        chk("reload_load", 32'(load), 32'd1);
        chk("reload_val", 32'(load_val), 32'd300);
        chk("reload_drawn", 32'(drawn), 32'd50);
        tick(3);
        chk("reload_last", 32'(load), 32'd1);
        tick(1);
        chk("reload_done_load", 32'(load), 32'd0);
        chk("reload_done_busy", 32'(busy), 32'd0);
        chk("reload_done_val", 32'(load_val), 32'd0);
        tick(3);
        chk("reload_no_fire", 32'(d_fires - f0), 32'd0);
        trigger = 0;
        tick(2);

        // Not armed: nothing. Then empty magazine: exactly one dry pulse.
        mode = 4'b0001; sel = 2'b11;
        f0 = d_fires; dr0 = d_drys;
        for (int i = 0; i < 10; i++) begin
            trigger = ~trigger;
            tick(1);
        end
        chk("unarmed_fire", 32'(d_fires - f0), 32'd0);
        chk("unarmed_dry", 32'(d_drys - dr0), 32'd0);
        mode = 4'b0010; sel = 2'b01; ammo = 9'd0; trigger = 0;
        tick(2);
        dr0 = d_drys; mdr0 = m_drys;
        trigger = 1;
        tick(1);
        chk("dry_pulse", 32'(dry), 32'd1);
        tick(1);
        chk("dry_once", 32'(dry), 32'd0);
        tick(3);
        chk("dry_count", 32'(d_drys - dr0), 32'd1);
        chk("dry_model", 32'(m_drys - mdr0), 32'd1);
        trigger = 0;

        // Reset during the second shot of a burst.
        sel = 2'b10; cooldown = 8'd0; ammo = 9'd50;
        tick(2);
        f0 = d_fires;
        trigger = 1;
        tick(2);
        chk("burst_pre_rst", 32'(fire), 32'd1);
        rst = 0;
        tick(1);
        chk("rst_fire", 32'(fire), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1;
        tick(10);
        chk("rst_shots", 32'(d_fires - f0), 32'd2);
        trigger = 0;
        tick(2);

        // Randomized traffic against the model.
        reserve = 9'd200;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            mode = ($urandom_range(0, 14) == 0) ? 4'($urandom_range(0, 15)) : 4'b0010;
            if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) trigger = ~trigger;
            reload_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) cooldown = 8'($urandom_range(0, 4));
            if (ph == PH_READY && $urandom_range(0, 29) == 0)
                ammo = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom_range(1, MAG));
            if ($urandom_range(0, 99) == 0) reserve = 9'($urandom_range(0, 400));
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
